// File: rtl/host_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// host_mem_pkg : FSM state encoding and byte-address to word-index helper
// Rev 1.0
// ----------------------------------------------------------------------------
package host_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_R_FETCH  = 3'd1,
        ST_R_VALID  = 3'd2,
        ST_R_WAIT   = 3'd3,
        ST_W_ACCEPT = 3'd4,
        ST_W_WAIT   = 3'd5
`ifdef HOST_MEM_BACKPRESSURE_EN
        ,
        ST_STALL    = 3'd6
`endif
    } state_t;

    function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
        return (addr - base) >> WORD_SHIFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_mem_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// host_mem_ram : true dual-port synchronous RAM, port A (FSM) wins collisions
// Rev 1.0
// ----------------------------------------------------------------------------
module host_mem_ram #(
    parameter int unsigned DEPTH    = 16384,
    parameter int unsigned ADDR_WID = 14,
    parameter int unsigned DATA_WID = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_re_i,
    input  logic                a_we_i,
    input  logic [ADDR_WID-1:0] a_addr_i,
    input  logic [DATA_WID-1:0] a_wdata_i,
    output logic [DATA_WID-1:0] a_rdata_o,
    input  logic                b_we_i,
    input  logic [ADDR_WID-1:0] b_addr_i,
    input  logic [DATA_WID-1:0] b_wdata_i,
    output logic [DATA_WID-1:0] b_rdata_o
);

    logic [DATA_WID-1:0] mem_q [DEPTH];
    logic [DATA_WID-1:0] a_rdata_q;
    logic [DATA_WID-1:0] b_rdata_q;

    // Array storage is never reset; only the output registers are.
    always_ff @(posedge clk) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (b_we_i && !(a_we_i && (a_addr_i == b_addr_i))) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    // Port A output only updates on reads so the last read beat stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_re_i) begin
                a_rdata_q <= mem_q[a_addr_i];
            end
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/host_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// host_mem_responder : host memory model serving the wrapper word-stream protocol
// Option macro HOST_MEM_BACKPRESSURE_EN adds stall_cycles and a STALL state.
// Rev 1.0
// ----------------------------------------------------------------------------
module host_mem_responder
    import host_mem_pkg::*;
#(
    parameter int unsigned DEPTH    = 16384,
    parameter int unsigned ADDR_WID = 14,
    parameter int unsigned DATA_WID = 32,
    parameter logic [63:0] MEM_BASE = 64'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic                finish_read,
    output logic [63:0]         read_ready,
    output logic [DATA_WID-1:0] read_data,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [DATA_WID-1:0] write_data,
    input  logic                finish_write,
    output logic [63:0]         write_ready,
    input  logic                done,
    output logic                done_seen,
    input  logic                host_we,
    input  logic [ADDR_WID-1:0] host_addr,
    input  logic [DATA_WID-1:0] host_wdata,
    output logic [DATA_WID-1:0] host_rdata,
    output logic                host_busy,
    output logic [31:0]         rd_beats,
    output logic [31:0]         wr_beats,
`ifdef HOST_MEM_BACKPRESSURE_EN
    input  logic [7:0]          stall_cycles,
`endif
    output logic                addr_err
);

    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    state_t              state_q, state_d;
    state_t              rd_tgt, wr_tgt;
    logic                read_ready_q, write_ready_q;
    logic                done_seen_q, addr_err_q, rd_oor_q;
    logic [31:0]         rd_beats_q, wr_beats_q;
    logic [63:0]         rd_idx, wr_idx;
    logic                rd_in_range, wr_in_range;
    logic                ram_re_a, ram_we_a;
    logic [ADDR_WID-1:0] ram_addr_a;
    logic [DATA_WID-1:0] ram_rdata_a;

    assign rd_idx      = word_index(read_addr, MEM_BASE);
    assign wr_idx      = word_index(write_addr, MEM_BASE);
    assign rd_in_range = (read_addr >= MEM_BASE) && (rd_idx < DEPTH_W);
    assign wr_in_range = (write_addr >= MEM_BASE) && (wr_idx < DEPTH_W);

`ifdef HOST_MEM_BACKPRESSURE_EN
    logic [7:0] stall_n_q, stall_cnt_q;
    logic       stall_ld_q, stall_wr_q;

    assign rd_tgt = (stall_n_q != 8'd0) ? ST_STALL : ST_R_VALID;
    assign wr_tgt = (stall_n_q != 8'd0) ? ST_STALL : ST_W_ACCEPT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_n_q   <= 8'd0;
            stall_cnt_q <= 8'd0;
            stall_ld_q  <= 1'b0;
            stall_wr_q  <= 1'b0;
        end else begin
            if (!stall_ld_q) begin
                stall_n_q  <= stall_cycles;
                stall_ld_q <= 1'b1;
            end
            if ((state_d == ST_STALL) && (state_q != ST_STALL)) begin
                stall_cnt_q <= stall_n_q;
                stall_wr_q  <= (state_q != ST_R_FETCH);
            end else if (state_q == ST_STALL) begin
                stall_cnt_q <= stall_cnt_q - 8'd1;
            end
        end
    end
`else
    assign rd_tgt = ST_R_VALID;
    assign wr_tgt = ST_W_ACCEPT;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (read_enable) begin
                    state_d = ST_R_FETCH;
                end else if (write_enable) begin
                    state_d = wr_tgt;
                end
            end
            ST_R_FETCH:  state_d = rd_tgt;
            ST_R_VALID:  state_d = ST_R_WAIT;
            ST_R_WAIT: begin
                if (finish_read) begin
                    state_d = ST_R_FETCH;
                end else if (!read_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_W_ACCEPT: state_d = ST_W_WAIT;
            ST_W_WAIT: begin
                if (finish_write) begin
                    state_d = wr_tgt;
                end else if (!write_enable) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef HOST_MEM_BACKPRESSURE_EN
            ST_STALL: begin
                if (stall_cnt_q <= 8'd1) begin
                    state_d = stall_wr_q ? ST_W_ACCEPT : ST_R_VALID;
                end
            end
`endif
            default:     state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            rd_beats_q    <= 32'd0;
            wr_beats_q    <= 32'd0;
            done_seen_q   <= 1'b0;
            addr_err_q    <= 1'b0;
            rd_oor_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_ready_q  <= (state_d == ST_R_VALID);
            write_ready_q <= (state_d == ST_W_ACCEPT);
            if (state_d == ST_R_VALID) begin
                rd_beats_q <= rd_beats_q + 32'd1;
            end
            if (state_d == ST_W_ACCEPT) begin
                wr_beats_q <= wr_beats_q + 32'd1;
            end
            if (state_q == ST_R_FETCH) begin
                rd_oor_q <= !rd_in_range;
                if (!rd_in_range) begin
                    addr_err_q <= 1'b1;
                end
            end
            if ((state_q == ST_W_ACCEPT) && !wr_in_range) begin
                addr_err_q <= 1'b1;
            end
            if (done) begin
                done_seen_q <= 1'b1;
            end
        end
    end

    assign ram_re_a   = (state_q == ST_R_FETCH);
    assign ram_we_a   = (state_q == ST_W_ACCEPT) && wr_in_range;
    assign ram_addr_a = (state_q == ST_W_ACCEPT) ? wr_idx[ADDR_WID-1:0] : rd_idx[ADDR_WID-1:0];

    host_mem_ram #(
        .DEPTH    (DEPTH),
        .ADDR_WID (ADDR_WID),
        .DATA_WID (DATA_WID)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .a_re_i    (ram_re_a),
        .a_we_i    (ram_we_a),
        .a_addr_i  (ram_addr_a),
        .a_wdata_i (write_data),
        .a_rdata_o (ram_rdata_a),
        .b_we_i    (host_we && !host_busy),
        .b_addr_i  (host_addr),
        .b_wdata_i (host_wdata),
        .b_rdata_o (host_rdata)
    );

    assign host_busy   = (state_q != ST_IDLE);
    assign read_ready  = {63'd0, read_ready_q};
    assign write_ready = {63'd0, write_ready_q};
    assign read_data   = rd_oor_q ? '0 : ram_rdata_a;
    assign rd_beats    = rd_beats_q;
    assign wr_beats    = wr_beats_q;
    assign done_seen   = done_seen_q;
    assign addr_err    = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_host_mem_responder.sv
`default_nettype none
// tb_host_mem_responder : random read/write streams checked against an array memory model
module tb_host_mem_responder;

    localparam int          DEPTH    = 16384;
    localparam int          ADDR_WID = 14;
    localparam logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000;
`ifdef HOST_MEM_BACKPRESSURE_EN
    localparam int STALL_N = 3;
`else
    localparam int STALL_N = 0;
`endif
    localparam int RD_LAT = 2 + STALL_N;
    localparam int WR_LAT = 1 + STALL_N;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable, finish_read, write_enable, finish_write, done, host_we;
    logic [63:0] read_addr, write_addr;
    logic [63:0] read_ready, write_ready;
    logic [31:0] read_data, write_data, host_wdata, host_rdata, rd_beats, wr_beats;
    logic [13:0] host_addr;
    logic        done_seen, host_busy, addr_err;
    logic [7:0]  stall_cycles = 8'(STALL_N);

    host_mem_responder #(.MEM_BASE(MEM_BASE)) dut (
        .clk(clk), .reset(reset),
        .read_enable(read_enable), .read_addr(read_addr), .finish_read(finish_read),
        .read_ready(read_ready), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .finish_write(finish_write), .write_ready(write_ready),
        .done(done), .done_seen(done_seen),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_busy(host_busy),
        .rd_beats(rd_beats), .wr_beats(wr_beats),
`ifdef HOST_MEM_BACKPRESSURE_EN
        .stall_cycles(stall_cycles),
`endif
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          exp_rd_beats = 0;
    int          exp_wr_beats = 0;
    int          rd_pulse_cnt = 0;
    int          wr_pulse_cnt = 0;
    logic [31:0] model_mem [DEPTH];
    logic [63:0] s_addr [16];
    logic [31:0] s_data [16];
    logic [31:0] s_got  [16];
    int          s_lat  [16];
    int          s_bad;

    always @(negedge clk) begin
        if (read_ready[0] === 1'b1) rd_pulse_cnt++;
        if (write_ready[0] === 1'b1) wr_pulse_cnt++;
    end

    function automatic logic in_range(input logic [63:0] a);
        return (a >= MEM_BASE) && (a < MEM_BASE + 64'(4 * DEPTH));
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a - MEM_BASE) / 64'd4);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [63:0] a);
        if (!in_range(a)) return 32'd0;
        return model_mem[idx_of(a)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int idx, input logic [31:0] d);
        host_we = 1'b1; host_addr = 14'(idx); host_wdata = d;
        tick();
        host_we = 1'b0;
        model_mem[idx] = d;
    endtask

    task automatic host_read(input int idx, output logic [31:0] d);
        host_addr = 14'(idx);
        tick();
        d = host_rdata;
    endtask

    task automatic rd_wait(output int lat);
        lat = 0;
        do begin
            tick(); finish_read = 1'b0; lat++;
        end while (read_ready[0] !== 1'b1 && lat < 64);
    endtask

    task automatic wr_wait(output int lat);
        lat = 0;
        do begin
            tick(); finish_write = 1'b0; lat++;
        end while (write_ready[0] !== 1'b1 && lat < 64);
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 64 && host_busy !== 1'b0; i++) tick();
    endtask

    // Drives n read beats from s_addr; records data/latency, counts over-long ready pulses.
    task automatic run_read_stream(input int n);
        int lat;
        s_bad = 0;
        for (int i = 0; i < n; i++) begin
            read_addr = s_addr[i];
            if (i == 0) read_enable = 1'b1; else finish_read = 1'b1;
            rd_wait(lat);
            s_lat[i] = lat; s_got[i] = read_data;
            exp_rd_beats++;
            tick();
            if (read_ready[0] !== 1'b0) s_bad++;
        end
        read_enable = 1'b0;
        idle_wait();
    endtask

    task automatic run_write_stream(input int n);
        int lat;
        s_bad = 0;
        for (int i = 0; i < n; i++) begin
            write_addr = s_addr[i]; write_data = s_data[i];
            if (i == 0) write_enable = 1'b1; else finish_write = 1'b1;
            wr_wait(lat);
            s_lat[i] = lat;
            exp_wr_beats++;
            tick();
            if (write_ready[0] !== 1'b0) s_bad++;
            if (in_range(s_addr[i])) model_mem[idx_of(s_addr[i])] = s_data[i];
        end
        write_enable = 1'b0;
        idle_wait();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if ({read_ready, write_ready} !== 128'd0) begin errors++;
            $display("FAIL reset_ready got %0h/%0h exp 0/0", read_ready, write_ready); end
        checks++; if ({read_data, host_rdata} !== 64'd0) begin errors++;
            $display("FAIL reset_data got %0h/%0h exp 0/0", read_data, host_rdata); end
        checks++; if ({rd_beats, wr_beats} !== 64'd0) begin errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", rd_beats, wr_beats); end
        checks++; if ({host_busy, addr_err, done_seen} !== 3'b000) begin errors++;
            $display("FAIL reset_flags got %b%b%b exp 000", host_busy, addr_err, done_seen); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_preload();
        logic [31:0] d;
        int idx;
        for (int i = 0; i < 256; i++) host_write(i, $urandom);
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, 255);
            host_read(idx, d);
            checks++; if (d !== model_mem[idx]) begin errors++;
                $display("FAIL host_rd[%0d] got %0h exp %0h", idx, d, model_mem[idx]); end
        end
    endtask

    task automatic test_read_stream();
        int p0;
        for (int i = 0; i < 4; i++) host_write(i, 32'(10 * (i + 1)));
        for (int i = 0; i < 4; i++) s_addr[i] = MEM_BASE + 64'(4 * i);
        p0 = rd_pulse_cnt;
        run_read_stream(4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (s_got[i] !== 32'(10 * (i + 1)) || s_lat[i] != RD_LAT) begin errors++;
                $display("FAIL rd_stream[%0d] got %0d lat %0d exp %0d lat %0d", i, s_got[i], s_lat[i], 10 * (i + 1), RD_LAT); end
        end
        checks++; if (s_bad != 0 || rd_pulse_cnt - p0 != 4) begin errors++;
            $display("FAIL rd_pulses got %0d long %0d exp 4 long 0", rd_pulse_cnt - p0, s_bad); end
        checks++; if (rd_beats !== 32'd4 || host_busy !== 1'b0) begin errors++;
            $display("FAIL rd_beats got %0d busy %b exp 4 busy 0", rd_beats, host_busy); end
    endtask

    task automatic test_write_stream();
        int p0;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin s_addr[i] = MEM_BASE + 64'(8 + 4 * i); s_data[i] = 32'(7 + i); end
        p0 = wr_pulse_cnt;
        run_write_stream(3);
        checks++; if (wr_pulse_cnt - p0 != 3 || s_bad != 0 || s_lat[0] != WR_LAT) begin errors++;
            $display("FAIL wr_pulses got %0d lat %0d exp 3 lat %0d", wr_pulse_cnt - p0, s_lat[0], WR_LAT); end
        for (int i = 2; i < 5; i++) begin
            host_read(i, d);
            checks++; if (d !== 32'(5 + i)) begin errors++;
                $display("FAIL wr_mem[%0d] got %0d exp %0d", i, d, 5 + i); end
        end
        checks++; if (wr_beats !== 32'(exp_wr_beats)) begin errors++;
            $display("FAIL wr_beats got %0d exp %0d", wr_beats, exp_wr_beats); end
    endtask

    task automatic test_both();
        int p0, lat;
        logic [31:0] wd, d;
        wd = $urandom;
        p0 = wr_pulse_cnt;
        read_addr = MEM_BASE + 64'd20; write_addr = MEM_BASE + 64'd24; write_data = wd;
        read_enable = 1'b1; write_enable = 1'b1;
        rd_wait(lat);
        exp_rd_beats++;
        checks++; if (read_data !== model_mem[5] || lat != RD_LAT) begin errors++;
            $display("FAIL both_rd got %0h lat %0d exp %0h lat %0d", read_data, lat, model_mem[5], RD_LAT); end
        tick(); tick();
        checks++; if (wr_pulse_cnt != p0) begin errors++;
            $display("FAIL both_early_wr got %0d pulses exp 0", wr_pulse_cnt - p0); end
        read_enable = 1'b0;
        wr_wait(lat);
        exp_wr_beats++;
        checks++; if (lat != WR_LAT + 1) begin errors++;
            $display("FAIL both_wr_lat got %0d exp %0d", lat, WR_LAT + 1); end
        tick();
        write_enable = 1'b0;
        model_mem[6] = wd;
        idle_wait();
        host_read(6, d);
        checks++; if (d !== wd) begin errors++;
            $display("FAIL both_wr_mem got %0h exp %0h", d, wd); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [31:0] d;
        read_addr = MEM_BASE + 64'd28; read_enable = 1'b1;
        rd_wait(lat);
        exp_rd_beats++;
        tick();
        checks++; if (host_busy !== 1'b1) begin errors++;
            $display("FAIL busy got %b exp 1", host_busy); end
        host_we = 1'b1; host_addr = 14'd7; host_wdata = ~model_mem[7];
        tick();
        host_we = 1'b0; read_enable = 1'b0;
        idle_wait();
        host_read(7, d);
        checks++; if (d !== model_mem[7]) begin errors++;
            $display("FAIL busy_ignore got %0h exp %0h", d, model_mem[7]); end
    endtask

    task automatic test_random();
        int n, idx;
        logic [31:0] d;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                s_addr[i] = MEM_BASE + 64'(4 * $urandom_range(0, 255)) + 64'($urandom_range(0, 3));
                s_data[i] = $urandom;
            end
            if ($urandom_range(0, 1) == 1) begin
                run_write_stream(n);
                for (int i = 0; i < n; i++) begin
                    idx = idx_of(s_addr[i]);
                    host_read(idx, d);
                    checks++; if (d !== model_mem[idx] || s_lat[i] != WR_LAT) begin errors++;
                        $display("FAIL rnd_wr[%0d] got %0h lat %0d exp %0h lat %0d", idx, d, s_lat[i], model_mem[idx], WR_LAT); end
                end
            end else begin
                run_read_stream(n);
                for (int i = 0; i < n; i++) begin
                    checks++; if (s_got[i] !== exp_rd(s_addr[i]) || s_lat[i] != RD_LAT) begin errors++;
                        $display("FAIL rnd_rd[%0h] got %0h lat %0d exp %0h lat %0d", s_addr[i], s_got[i], s_lat[i], exp_rd(s_addr[i]), RD_LAT); end
                end
            end
            checks++; if (s_bad != 0) begin errors++;
                $display("FAIL rnd_pulse_width got %0d long exp 0", s_bad); end
        end
        checks++; if (rd_beats !== 32'(exp_rd_beats) || wr_beats !== 32'(exp_wr_beats)) begin errors++;
            $display("FAIL rnd_beats got %0d/%0d exp %0d/%0d", rd_beats, wr_beats, exp_rd_beats, exp_wr_beats); end
    endtask

    task automatic test_done();
        checks++; if (done_seen !== 1'b0) begin errors++;
            $display("FAIL done_pre got %b exp 0", done_seen); end
        done = 1'b1; tick(); done = 1'b0; tick(); tick();
        checks++; if (done_seen !== 1'b1) begin errors++;
            $display("FAIL done_sticky got %b exp 1", done_seen); end
    endtask

    task automatic test_oor();
        logic [31:0] d;
        checks++; if (addr_err !== 1'b0) begin errors++;
            $display("FAIL oor_pre got %b exp 0", addr_err); end
        s_addr[0] = MEM_BASE + 64'(4 * DEPTH);
        s_addr[1] = MEM_BASE - 64'd4;
        run_read_stream(2);
        checks++; if (s_got[0] !== 32'd0 || s_got[1] !== 32'd0 || s_lat[0] != RD_LAT) begin errors++;
            $display("FAIL oor_rd got %0h/%0h lat %0d exp 0/0 lat %0d", s_got[0], s_got[1], s_lat[0], RD_LAT); end
        checks++; if (addr_err !== 1'b1) begin errors++;
            $display("FAIL oor_err got %b exp 1", addr_err); end
        s_addr[0] = MEM_BASE + 64'(4 * DEPTH); s_data[0] = ~model_mem[0];
        run_write_stream(1);
        host_read(0, d);
        checks++; if (d !== model_mem[0] || s_lat[0] != WR_LAT) begin errors++;
            $display("FAIL oor_wr got %0h lat %0d exp %0h lat %0d", d, s_lat[0], model_mem[0], WR_LAT); end
    endtask

    task automatic test_reset_mid();
        int lat;
        read_addr = MEM_BASE + 64'd4; read_enable = 1'b1;
        rd_wait(lat);
        checks++; if (read_ready[0] !== 1'b1) begin errors++;
            $display("FAIL rst_mid_pre got %b exp 1", read_ready[0]); end
        #2 reset = 1'b1;
        #1;
        checks++; if (read_ready !== 64'd0 || host_busy !== 1'b0) begin errors++;
            $display("FAIL rst_mid_async got %0h busy %b exp 0 busy 0", read_ready, host_busy); end
        read_enable = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        exp_rd_beats = 0; exp_wr_beats = 0;
        checks++; if ({rd_beats, wr_beats} !== 64'd0 || {host_busy, addr_err, done_seen} !== 3'b000) begin errors++;
            $display("FAIL rst_mid_post got %0d/%0d flags %b%b%b exp 0/0 000", rd_beats, wr_beats, host_busy, addr_err, done_seen); end
    endtask

`ifdef HOST_MEM_BACKPRESSURE_EN
    task automatic test_stall();
        s_addr[0] = MEM_BASE + 64'd8;
        run_read_stream(1);
        checks++; if (s_lat[0] != 5 || s_got[0] !== model_mem[2]) begin errors++;
            $display("FAIL stall_rd lat %0d data %0h exp 5 %0h", s_lat[0], s_got[0], model_mem[2]); end
        s_addr[0] = MEM_BASE + 64'd12; s_data[0] = $urandom;
        s_addr[1] = MEM_BASE + 64'd16; s_data[1] = $urandom;
        run_write_stream(2);
        checks++; if (s_lat[0] != 4 || s_lat[1] != 4) begin errors++;
            $display("FAIL stall_wr lat %0d/%0d exp 4/4", s_lat[0], s_lat[1]); end
    endtask
`endif

    initial begin
        read_enable = 0; finish_read = 0; write_enable = 0; finish_write = 0;
        done = 0; host_we = 0; read_addr = '0; write_addr = '0; write_data = '0;
        host_addr = '0; host_wdata = '0;
        test_reset();
        test_preload();
        test_read_stream();
        test_write_stream();
        test_both();
        test_busy_ignore();
        test_random();
        test_done();
        test_oor();
        test_reset_mid();
`ifdef HOST_MEM_BACKPRESSURE_EN
        test_stall();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
